// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze tile renderer and the
// level ROM.
//   tile_t      : 2-bit tile type stored in the map RAM and the level ROM
//   TILES_X/Y   : map dimensions in tiles (16x16-pixel tiles on a 640x480 screen)
//   WALL_RGB    : wall colour
//   DOT_RGB     : dot and power-pellet colour
//   tile_addr() : linear map address ty*40+tx
//   dbg_t       : packed snapshot of both FSM states for observation
package maze_pkg;

  localparam int TILES_X  = 40;
  localparam int TILES_Y  = 30;
  localparam int MAP_SIZE = TILES_X * TILES_Y;

  localparam logic [10:0] LAST_ADDR = 11'(MAP_SIZE - 1);

  localparam logic [23:0] WALL_RGB = 24'h2121DE;
  localparam logic [23:0] DOT_RGB  = 24'hFFB8AE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    DOT   = 2'd2,
    POWER = 2'd3
  } tile_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } top_state_t;

  typedef enum logic [1:0] {
    EAT_IDLE = 2'd0,
    EAT_RD   = 2'd1,
    EAT_WR   = 2'd2,
    EAT_ACK  = 2'd3
  } eat_state_t;

  typedef struct packed {
    top_state_t top;
    eat_state_t eat;
  } dbg_t;

  function automatic logic [10:0] tile_addr(input logic [4:0] ty, input logic [5:0] tx);
    return 11'(ty) * 11'(TILES_X) + 11'(tx);
  endfunction

  function automatic logic is_pellet(input tile_t t);
    return (t == DOT) || (t == POWER);
  endfunction

endpackage

// File: rtl/maze_rom.sv
// maze_rom: combinational level-1 layout, also used by the ghost-AI wall
// lookup.
//   addr : linear tile address ty*40+tx (addresses past the map read as WALL)
//   tile : tile type at that address
// Layout: solid border; dot corridors along rows 1, 10, 19, 28 and columns
// 1, 13, 26, 38; power pellets in the four corridor corners; a four-tile
// empty ghost-house gap on row 10 (columns 18..21); everything else is wall.
// Pellet total: 4*38 + 4*(28-4) - 4 = 244.
module maze_rom
  import maze_pkg::*;
(
  input  logic [10:0] addr,
  output tile_t       tile
);

  logic [10:0] ty;
  logic [10:0] tx;
  logic        border;
  logic        dot_row;
  logic        dot_col;
  logic        corner;
  logic        gap;

  always_comb begin
    ty      = addr / 11'd40;
    tx      = addr - ty * 11'd40;
    border  = (tx == 11'd0) || (tx == 11'd39) || (ty == 11'd0) || (ty == 11'd29);
    dot_row = (ty == 11'd1) || (ty == 11'd10) || (ty == 11'd19) || (ty == 11'd28);
    dot_col = (tx == 11'd1) || (tx == 11'd13) || (tx == 11'd26) || (tx == 11'd38);
    corner  = ((tx == 11'd1) || (tx == 11'd38)) && ((ty == 11'd1) || (ty == 11'd28));
    gap     = (ty == 11'd10) && (tx >= 11'd18) && (tx <= 11'd21);

    tile = WALL;
    if (addr > LAST_ADDR) begin
      tile = WALL;
    end else if (border) begin
      tile = WALL;
    end else if (corner) begin
      tile = POWER;
    end else if (gap) begin
      tile = EMPTY;
    end else if (dot_row || dot_col) begin
      tile = DOT;
    end else begin
      tile = WALL;
    end
  end

endmodule

// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: maze background renderer and live tile map.
//   Clk, Reset          : system clock, synchronous active-high reset
//   pixel_en            : one-cycle strobe per pixel
//   DrawX, DrawY, blank : raster position and active-low display enable
//   Red, Green, Blue    : background colour, held between strobes
//   rgb_valid           : one-cycle pulse, colour is for the pixel strobed
//                         two cycles earlier
//   eat_req/eat_tx/eat_ty, eat_ack/eat_type : pellet-eat request/response
//   dots_left           : remaining dots plus power pellets
//   init_done           : map reload from the level ROM has completed
//   dbg_state           : current top and eat FSM states
//
// Eat handshake: the requester raises eat_req with a stable eat_tx/eat_ty
// and holds all three until it sees eat_ack. The request is taken when
// eat_req is high in IDLE during RUN; eat_ack pulses for one cycle on the
// third edge after that, with eat_type holding the tile type found. While
// eat_ack is high no new request is taken, so a requester that drops
// eat_req on seeing eat_ack is never served twice.
module maze_tile_renderer
  import maze_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pixel_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        rgb_valid,
  input  logic        eat_req,
  input  logic [5:0]  eat_tx,
  input  logic [4:0]  eat_ty,
  output logic        eat_ack,
  output logic [1:0]  eat_type,
  output logic [10:0] dots_left,
  output logic        init_done,
  output dbg_t        dbg_state
);

  // ---------------------------------------------------------------- state
  top_state_t  top_state, top_next;
  eat_state_t  eat_state, eat_next;
  logic [10:0] idx;

  logic [10:0] eat_addr;
  logic        eat_bad;
  tile_t       eat_old;

  // render pipeline registers (stage between RAM read and colour)
  logic        v1;
  logic        in_range1;
  logic [3:0]  ox1;
  logic [3:0]  oy1;

  // ---------------------------------------------------------------- ROM
  tile_t rom_tile;

  maze_rom u_rom (
    .addr (idx),
    .tile (rom_tile)
  );

  // ---------------------------------------------------------------- map RAM
  tile_t       mem [MAP_SIZE];
  tile_t       q_a;
  tile_t       q_b;
  logic [10:0] addr_a;
  logic        render_hit;
  logic        render_in_range;
  logic        we_b;
  logic [10:0] addr_b;
  tile_t       wdata_b;

  // Port A: render reads. Port B: reload writes and eat read-modify-write.
  // Both ports read the pre-write contents, so a render read that collides
  // with an eat write sees the old tile for one frame.
  always_ff @(posedge Clk) begin
    if (render_hit) begin
      q_a <= mem[addr_a];
    end
    if (we_b) begin
      mem[addr_b] <= wdata_b;
    end
    q_b <= mem[addr_b];
  end

  // ---------------------------------------------------------------- render address
  always_comb begin
    render_in_range = blank && (DrawX < 10'd640) && (DrawY < 10'd480);
    render_hit      = pixel_en && (top_state == ST_RUN);
    // Off-screen positions would index past the map; park them on tile 0,
    // their colour is forced to black anyway.
    addr_a = render_in_range ? tile_addr(DrawY[8:4], DrawX[9:4]) : 11'd0;
  end

  // ---------------------------------------------------------------- colour decode
  logic [23:0] pix_rgb;
  logic        dot_box;
  logic        power_box;

  always_comb begin
    dot_box   = (ox1 >= 4'd6) && (ox1 <= 4'd9) && (oy1 >= 4'd6) && (oy1 <= 4'd9);
    power_box = (ox1 >= 4'd2) && (ox1 <= 4'd13) && (oy1 >= 4'd2) && (oy1 <= 4'd13);
    pix_rgb   = 24'h000000;
    case (q_a)
      WALL:    pix_rgb = WALL_RGB;
      DOT:     pix_rgb = dot_box ? DOT_RGB : 24'h000000;
      POWER:   pix_rgb = power_box ? DOT_RGB : 24'h000000;
      default: pix_rgb = 24'h000000;
    endcase
  end

  // ---------------------------------------------------------------- eat decode
  logic eat_tile_bad;
  logic eat_accept;
  logic eat_write;

  always_comb begin
    eat_tile_bad = (eat_tx > 6'd39) || (eat_ty > 5'd29);
    eat_accept   = (eat_state == EAT_IDLE) && (top_state == ST_RUN) && eat_req && !eat_ack;
    eat_write    = (eat_state == EAT_WR) && !eat_bad && is_pellet(q_b);
  end

  // ---------------------------------------------------------------- port B mux
  always_comb begin
    we_b    = 1'b0;
    addr_b  = eat_addr;
    wdata_b = EMPTY;
    if (top_state == ST_INIT) begin
      we_b    = 1'b1;
      addr_b  = idx;
      wdata_b = rom_tile;
    end else if (eat_write) begin
      we_b    = 1'b1;
      addr_b  = eat_addr;
      wdata_b = EMPTY;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    top_next = top_state;
    case (top_state)
      ST_INIT: if (idx == LAST_ADDR) top_next = ST_RUN;
      ST_RUN:  top_next = ST_RUN;
      default: top_next = ST_INIT;
    endcase
  end

  always_comb begin
    eat_next = eat_state;
    case (eat_state)
      EAT_IDLE: if (eat_accept) eat_next = EAT_RD;
      EAT_RD:   eat_next = EAT_WR;
      EAT_WR:   eat_next = EAT_ACK;
      EAT_ACK:  eat_next = EAT_IDLE;
      default:  eat_next = EAT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- control registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      top_state <= ST_INIT;
      idx       <= 11'd0;
      init_done <= 1'b0;
      dots_left <= 11'd0;
      eat_state <= EAT_IDLE;
      eat_addr  <= 11'd0;
      eat_bad   <= 1'b0;
      eat_old   <= EMPTY;
      eat_ack   <= 1'b0;
      eat_type  <= 2'd0;
    end else begin
      top_state <= top_next;
      eat_state <= eat_next;

      if (top_state == ST_INIT) begin
        if (idx != LAST_ADDR) begin
          idx <= idx + 11'd1;
        end else begin
          init_done <= 1'b1;
        end
        if (is_pellet(rom_tile)) begin
          dots_left <= dots_left + 11'd1;
        end
      end else if (eat_write && (dots_left != 11'd0)) begin
        dots_left <= dots_left - 11'd1;
      end

      if (eat_accept) begin
        // Out-of-map requests never touch the RAM; they answer as WALL.
        eat_addr <= eat_tile_bad ? 11'd0 : tile_addr(eat_ty, eat_tx);
        eat_bad  <= eat_tile_bad;
      end

      if (eat_state == EAT_WR) begin
        eat_old <= eat_bad ? WALL : q_b;
      end

      eat_ack <= (eat_state == EAT_ACK);
      if (eat_state == EAT_ACK) begin
        eat_type <= eat_old;
      end
    end
  end

  // ---------------------------------------------------------------- render registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1        <= 1'b0;
      in_range1 <= 1'b0;
      ox1       <= 4'd0;
      oy1       <= 4'd0;
      rgb_valid <= 1'b0;
      Red       <= 8'd0;
      Green     <= 8'd0;
      Blue      <= 8'd0;
    end else begin
      v1        <= render_hit;
      rgb_valid <= v1;
      if (render_hit) begin
        ox1       <= DrawX[3:0];
        oy1       <= DrawY[3:0];
        in_range1 <= render_in_range;
      end
      if (v1) begin
        {Red, Green, Blue} <= in_range1 ? pix_rgb : 24'h000000;
      end
    end
  end

  assign dbg_state = '{top: top_state, eat: eat_state};

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Directed bench for maze_tile_renderer: map reload, rendering of walls,
// dots, power pellets and off-screen pixels, pellet eating, and reset
// during an eat.
module tb_maze_tile_renderer;
  import maze_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pixel_en = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        blank = 1'b0;
  logic        eat_req = 1'b0;
  logic [5:0]  eat_tx = 6'd0;
  logic [4:0]  eat_ty = 5'd0;
  logic [7:0]  Red, Green, Blue;
  logic        rgb_valid;
  logic        eat_ack;
  logic [1:0]  eat_type;
  logic [10:0] dots_left;
  logic        init_done;
  dbg_t        dbg_state;

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  maze_tile_renderer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .pixel_en  (pixel_en),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .Red       (Red),
    .Green     (Green),
    .Blue      (Blue),
    .rgb_valid (rgb_valid),
    .eat_req   (eat_req),
    .eat_tx    (eat_tx),
    .eat_ty    (eat_ty),
    .eat_ack   (eat_ack),
    .eat_type  (eat_type),
    .dots_left (dots_left),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Strobe one pixel and sample the response: one cycle after the strobe
  // edge, two cycles after it (the valid slot), and three (held value).
  task automatic draw_pixel(input logic [9:0] x, input logic [9:0] y, input logic b,
                            output logic v_early, output logic v,
                            output logic [23:0] rgb, output logic v_late,
                            output logic [23:0] rgb_late);
    DrawX = x; DrawY = y; blank = b; pixel_en = 1'b1;
    step();
    v_early = rgb_valid;
    pixel_en = 1'b0;
    step();
    v   = rgb_valid;
    rgb = {Red, Green, Blue};
    step();
    v_late   = rgb_valid;
    rgb_late = {Red, Green, Blue};
    blank = 1'b0;
  endtask

  // Issue one eat request and sample at the 2nd edge (ack must still be low,
  // dots_left already updated), the 3rd edge (ack pulse) and the 4th edge.
  task automatic do_eat(input logic [5:0] tx, input logic [4:0] ty,
                        output logic ack_e2, output logic [10:0] dots_e2,
                        output logic ack_e3, output logic [1:0] type_e3,
                        output logic ack_after);
    eat_tx = tx; eat_ty = ty; eat_req = 1'b1;
    step();
    step();
    step();
    ack_e2  = eat_ack;
    dots_e2 = dots_left;
    step();
    ack_e3  = eat_ack;
    type_e3 = eat_type;
    eat_req = 1'b0;
    step();
    ack_after = eat_ack;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if ({Red, Green, Blue, rgb_valid, eat_ack, eat_type, dots_left, init_done} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: rgb=%h valid=%b ack=%b type=%0d dots=%0d done=%b, required all zero",
               {Red, Green, Blue}, rgb_valid, eat_ack, eat_type, dots_left, init_done);
    end
  endtask

  task automatic test_init();
    Reset = 1'b0;
    for (int i = 0; i < 1199; i++) begin
      pixel_en = (i == 100);
      DrawX = 10'd20; DrawY = 10'd5; blank = 1'b1;
      step();
      if (i == 101) begin
        checks++;
        if (rgb_valid !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin
          fails++;
          $display("FAIL render_during_init: valid=%b rgb=%h, required 0 000000", rgb_valid, {Red, Green, Blue});
        end
      end
    end
    pixel_en = 1'b0; blank = 1'b0;
    checks++;
    if (init_done !== 1'b0) begin
      fails++;
      $display("FAIL init_done_early: got %b after 1199 cycles, required 0", init_done);
    end
    step();
    checks++;
    if (init_done !== 1'b1) begin
      fails++;
      $display("FAIL init_done_rise: got %b after 1200 cycles, required 1", init_done);
    end
    checks++;
    if (dots_left !== 11'd244) begin
      fails++;
      $display("FAIL init_dot_count: got %0d, required 244", dots_left);
    end
  endtask

  task automatic test_wall_latency();
    logic v_early, v, v_late;
    logic [23:0] rgb, rgb_late;
    draw_pixel(10'd20, 10'd5, 1'b1, v_early, v, rgb, v_late, rgb_late);
    checks++;
    if (v_early !== 1'b0) begin
      fails++;
      $display("FAIL wall_valid_early: got %b one cycle after strobe, required 0", v_early);
    end
    checks++;
    if (v !== 1'b1 || rgb !== 24'h2121DE) begin
      fails++;
      $display("FAIL wall_pixel: valid=%b rgb=%h, required 1 2121de", v, rgb);
    end
    checks++;
    if (v_late !== 1'b0 || rgb_late !== 24'h2121DE) begin
      fails++;
      $display("FAIL wall_hold: valid=%b rgb=%h, required 0 2121de", v_late, rgb_late);
    end
  endtask

  task automatic test_render_table();
    logic [9:0]  xs [12] = '{10'd39, 10'd32, 10'd41, 10'd42, 10'd39, 10'd18,
                             10'd17, 10'd296, 10'd700, 10'd20, 10'd620, 10'd616};
    logic [9:0]  ys [12] = '{10'd23, 10'd16, 10'd22, 10'd23, 10'd23, 10'd29,
                             10'd21, 10'd168, 10'd5, 10'd490, 10'd470, 10'd456};
    logic        bs [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [23:0] es [12] = '{24'hFFB8AE, 24'h000000, 24'hFFB8AE, 24'h000000,
                             24'h000000, 24'hFFB8AE, 24'h000000, 24'h000000,
                             24'h000000, 24'h000000, 24'h2121DE, 24'hFFB8AE};
    logic v_early, v, v_late;
    logic [23:0] rgb, rgb_late;
    for (int i = 0; i < 12; i++) begin
      draw_pixel(xs[i], ys[i], bs[i], v_early, v, rgb, v_late, rgb_late);
      checks++;
      if (v !== 1'b1 || rgb !== es[i]) begin
        fails++;
        $display("FAIL render_vec%0d (x=%0d y=%0d blank=%b): valid=%b rgb=%h, required 1 %h",
                 i, xs[i], ys[i], bs[i], v, rgb, es[i]);
      end
    end
  endtask

  task automatic test_eat_dot();
    logic ack_e2, ack_e3, ack_after, v_early, v, v_late;
    logic [10:0] dots_e2;
    logic [1:0]  type_e3;
    logic [23:0] rgb, rgb_late;
    do_eat(6'd2, 5'd1, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e2 !== 1'b0 || dots_e2 !== 11'd243) begin
      fails++;
      $display("FAIL eat_dot_wr_edge: ack=%b dots=%0d, required 0 243", ack_e2, dots_e2);
    end
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd2 || ack_after !== 1'b0) begin
      fails++;
      $display("FAIL eat_dot_ack: ack=%b type=%0d ack_next=%b, required 1 2 0", ack_e3, type_e3, ack_after);
    end
    do_eat(6'd2, 5'd1, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd0 || dots_e2 !== 11'd243) begin
      fails++;
      $display("FAIL eat_dot_repeat: ack=%b type=%0d dots=%0d, required 1 0 243", ack_e3, type_e3, dots_e2);
    end
    draw_pixel(10'd39, 10'd23, 1'b1, v_early, v, rgb, v_late, rgb_late);
    checks++;
    if (v !== 1'b1 || rgb !== 24'h000000) begin
      fails++;
      $display("FAIL eaten_pixel: valid=%b rgb=%h, required 1 000000", v, rgb);
    end
  endtask

  task automatic test_eat_wall();
    logic ack_e2, ack_e3, ack_after, v_early, v, v_late;
    logic [10:0] dots_e2;
    logic [1:0]  type_e3;
    logic [23:0] rgb, rgb_late;
    do_eat(6'd1, 5'd0, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd1 || dots_e2 !== 11'd243) begin
      fails++;
      $display("FAIL eat_wall: ack=%b type=%0d dots=%0d, required 1 1 243", ack_e3, type_e3, dots_e2);
    end
    do_eat(6'd45, 5'd3, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd1 || dots_e2 !== 11'd243) begin
      fails++;
      $display("FAIL eat_off_map: ack=%b type=%0d dots=%0d, required 1 1 243", ack_e3, type_e3, dots_e2);
    end
    draw_pixel(10'd20, 10'd5, 1'b1, v_early, v, rgb, v_late, rgb_late);
    checks++;
    if (v !== 1'b1 || rgb !== 24'h2121DE) begin
      fails++;
      $display("FAIL wall_after_eat: valid=%b rgb=%h, required 1 2121de", v, rgb);
    end
  endtask

  task automatic test_eat_power();
    logic ack_e2, ack_e3, ack_after, v_early, v, v_late;
    logic [10:0] dots_e2;
    logic [1:0]  type_e3;
    logic [23:0] rgb, rgb_late;
    do_eat(6'd38, 5'd28, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd3 || dots_e2 !== 11'd242) begin
      fails++;
      $display("FAIL eat_power: ack=%b type=%0d dots=%0d, required 1 3 242", ack_e3, type_e3, dots_e2);
    end
    draw_pixel(10'd616, 10'd456, 1'b1, v_early, v, rgb, v_late, rgb_late);
    checks++;
    if (v !== 1'b1 || rgb !== 24'h000000) begin
      fails++;
      $display("FAIL power_eaten_pixel: valid=%b rgb=%h, required 1 000000", v, rgb);
    end
  endtask

  task automatic test_back_to_back();
    logic ack_e2, ack_e3, ack_after;
    logic [10:0] dots_e2;
    logic [1:0]  type_e3;
    do_eat(6'd3, 5'd1, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd2 || dots_e2 !== 11'd241) begin
      fails++;
      $display("FAIL b2b_first: ack=%b type=%0d dots=%0d, required 1 2 241", ack_e3, type_e3, dots_e2);
    end
    do_eat(6'd13, 5'd5, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd2 || dots_e2 !== 11'd240) begin
      fails++;
      $display("FAIL b2b_second: ack=%b type=%0d dots=%0d, required 1 2 240", ack_e3, type_e3, dots_e2);
    end
  endtask

  task automatic test_reset_mid_eat();
    int ack_seen = 0;
    logic ack_e2, ack_e3, ack_after, v_early, v, v_late;
    logic [10:0] dots_e2;
    logic [1:0]  type_e3;
    logic [23:0] rgb, rgb_late;
    eat_tx = 6'd4; eat_ty = 5'd1; eat_req = 1'b1;
    step();
    Reset = 1'b1; eat_req = 1'b0;
    step();
    if (eat_ack === 1'b1) ack_seen++;
    step();
    if (eat_ack === 1'b1) ack_seen++;
    Reset = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (eat_ack === 1'b1) ack_seen++;
    end
    checks++;
    if (ack_seen != 0) begin
      fails++;
      $display("FAIL reset_mid_eat_ack: saw %0d ack cycles, required 0", ack_seen);
    end
    checks++;
    if (init_done !== 1'b1 || dots_left !== 11'd244) begin
      fails++;
      $display("FAIL reinit: done=%b dots=%0d, required 1 244", init_done, dots_left);
    end
    draw_pixel(10'd39, 10'd23, 1'b1, v_early, v, rgb, v_late, rgb_late);
    checks++;
    if (v !== 1'b1 || rgb !== 24'hFFB8AE) begin
      fails++;
      $display("FAIL reinit_dot_restored: valid=%b rgb=%h, required 1 ffb8ae", v, rgb);
    end
    do_eat(6'd4, 5'd1, ack_e2, dots_e2, ack_e3, type_e3, ack_after);
    checks++;
    if (ack_e3 !== 1'b1 || type_e3 !== 2'd2 || dots_e2 !== 11'd243) begin
      fails++;
      $display("FAIL aborted_tile_intact: ack=%b type=%0d dots=%0d, required 1 2 243", ack_e3, type_e3, dots_e2);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_init();
    test_wall_latency();
    test_render_table();
    test_eat_dot();
    test_eat_wall();
    test_eat_power();
    test_back_to_back();
    test_reset_mid_eat();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
